// File: rtl/video_timing_pkg.sv
// Shared raster geometry for the video timing generator.
// Progressive VGA 640x480 and NTSC-rate interlaced constants.
package video_timing_pkg;

    localparam int P_H_ACTIVE = 640;
    localparam int P_H_FP     = 16;
    localparam int P_H_SYNC   = 96;
    localparam int P_H_BP     = 48;
    localparam int P_V_ACTIVE = 480;
    localparam int P_V_FP     = 10;
    localparam int P_V_SYNC   = 2;
    localparam int P_V_BP     = 33;

    localparam int I_H_ACTIVE = 1280;
    localparam int I_H_FP     = 32;
    localparam int I_H_SYNC   = 118;
    localparam int I_H_BP     = 158;
    localparam int I_H_HALF   = 794;
    localparam int I_V_ACTIVE = 240;
    localparam int I_V_FP     = 3;
    localparam int I_V_SYNC   = 3;
    localparam int I_V_BP     = 16;

    // Active size, sync window and half-line point of one raster mode.
    typedef struct packed {
        logic [10:0] h_act;
        logic [10:0] h_ss;
        logic [10:0] h_se;
        logic [10:0] h_half;
        logic [9:0]  v_act;
        logic [9:0]  v_ss;
        logic [9:0]  v_se;
    } timing_t;

    localparam timing_t PROG_TIMING = '{
        h_act:  11'(P_H_ACTIVE),
        h_ss:   11'(P_H_ACTIVE + P_H_FP),
        h_se:   11'(P_H_ACTIVE + P_H_FP + P_H_SYNC),
        h_half: 11'((P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP) / 2),
        v_act:  10'(P_V_ACTIVE),
        v_ss:   10'(P_V_ACTIVE + P_V_FP),
        v_se:   10'(P_V_ACTIVE + P_V_FP + P_V_SYNC)
    };

    localparam timing_t INTL_TIMING = '{
        h_act:  11'(I_H_ACTIVE),
        h_ss:   11'(I_H_ACTIVE + I_H_FP),
        h_se:   11'(I_H_ACTIVE + I_H_FP + I_H_SYNC),
        h_half: 11'(I_H_HALF),
        v_act:  10'(I_V_ACTIVE),
        v_ss:   10'(I_V_ACTIVE + I_V_FP),
        v_se:   10'(I_V_ACTIVE + I_V_FP + I_V_SYNC)
    };

    // Picks the geometry (H/V active size and syncs) for the latched mode.
    function automatic timing_t select_timing(
        input logic    interlaced,
        input timing_t prog,
        input timing_t intl
    );
        return interlaced ? intl : prog;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Display-side bundle: composer strobes/data in, DAC signals out.
// master is the timing generator, slave is the composer/output side.
interface video_timing_if;

    logic       interlaced;
    logic       display_next_frame;
    logic       display_next_line;
    logic       display_next_pixel;
    logic       display_current_field;
    logic [7:0] display_data;
    logic [7:0] vid_data;
    logic       vid_hsync;
    logic       vid_vsync;
    logic       vid_blank;

    modport master (
        input  interlaced,
        input  display_data,
        output display_next_frame,
        output display_next_line,
        output display_next_pixel,
        output display_current_field,
        output vid_data,
        output vid_hsync,
        output vid_vsync,
        output vid_blank
    );

    modport slave (
        output interlaced,
        output display_data,
        input  display_next_frame,
        input  display_next_line,
        input  display_next_pixel,
        input  display_current_field,
        input  vid_data,
        input  vid_hsync,
        input  vid_vsync,
        input  vid_blank
    );

endinterface

// File: rtl/video_delay_line.sv
// DEPTH-stage shift register advancing on en.
// Aligns sync/blank with the composer's pipelined pixel data.
module video_delay_line #(
    parameter int              DEPTH   = 2,
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("video_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift one stage per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: composer strobes, field tracking,
// and re-timed pixel/sync/blank output for the palette/DAC.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int      PIPE_DELAY = 2,
    parameter int      H_TOTAL_P  = 800,
    parameter int      V_TOTAL_P  = 525,
    parameter int      H_TOTAL_I  = 1588,
    parameter int      V_TOTAL_I  = 262,
    parameter timing_t TP         = PROG_TIMING,
    parameter timing_t TI         = INTL_TIMING
) (
    input  logic          clk,
    input  logic          rst_n,
    video_timing_if.master bus
);

    if (PIPE_DELAY < 1) begin : g_bad_delay
        $error("video_timing_gen: PIPE_DELAY must be at least 1");
    end

    logic        clk_en;
    logic [10:0] h;
    logic [9:0]  v;
    logic        field;
    logic        mode_r;

    timing_t     tm;
    logic [10:0] h_total;
    logic [9:0]  v_total;
    logic        line_end;
    logic        frame_end;
    logic        active;
    logic        hs_on;
    logic        vs_full;
    logic        vs_half;
    logic        vs_on;

    logic        pix_r;
    logic        line_r;
    logic        frame_r;
    logic        field_r;
    logic        blank_r;
    logic        hs_r;
    logic        vs_r;

    logic        blank_d;
    logic        hs_d;
    logic        vs_d;

    logic [7:0]  data_o;
    logic        blank_o;
    logic        hs_o;
    logic        vs_o;

    assign tm      = select_timing(mode_r, TP, TI);
    assign h_total = mode_r ? 11'(H_TOTAL_I) : 11'(H_TOTAL_P);
    assign v_total = mode_r ? 10'(V_TOTAL_I) + {9'd0, field}
                            : 10'(V_TOTAL_P);

    assign line_end  = (h == h_total - 11'd1);
    assign frame_end = line_end && (v == v_total - 10'd1);
    assign active    = (h < tm.h_act) && (v < tm.v_act);
    assign hs_on     = (h >= tm.h_ss) && (h < tm.h_se);

    // Field 1 of an interlaced frame starts/ends vsync mid-line.
    assign vs_full = (v >= tm.v_ss) && (v < tm.v_se);
    assign vs_half = ((v > tm.v_ss) || (v == tm.v_ss && h >= tm.h_half))
                  && ((v < tm.v_se) || (v == tm.v_se && h < tm.h_half));
    assign vs_on   = (mode_r && field) ? vs_half : vs_full;

    // Half-rate pixel enable, phase-locked to reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_en <= 1'b0;
        else        clk_en <= ~clk_en;
    end

    // Raster counters; mode and field only change at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h      <= '0;
            v      <= '0;
            field  <= 1'b0;
            mode_r <= 1'b0;
        end else if (clk_en) begin
            if (line_end) begin
                h <= '0;
                if (frame_end) begin
                    v      <= '0;
                    mode_r <= bus.interlaced;
                    field  <= bus.interlaced & mode_r & ~field;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 11'd1;
            end
        end
    end

    // Composer strobes plus undelayed sync/blank for the same pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r   <= 1'b0;
            line_r  <= 1'b0;
            frame_r <= 1'b0;
            field_r <= 1'b0;
            blank_r <= 1'b1;
            hs_r    <= 1'b1;
            vs_r    <= 1'b1;
        end else if (clk_en) begin
            pix_r   <= active;
            line_r  <= line_end;
            frame_r <= frame_end;
            field_r <= field;
            blank_r <= ~active;
            hs_r    <= ~hs_on;
            vs_r    <= ~vs_on;
        end
    end

    video_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   (3),
        .RST_VAL (3'b111)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (clk_en),
        .d     ({blank_r, hs_r, vs_r}),
        .q     ({blank_d, hs_d, vs_d})
    );

    // Capture the composer's pixel together with its aligned sync/blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            blank_o <= 1'b1;
            hs_o    <= 1'b1;
            vs_o    <= 1'b1;
        end else if (clk_en) begin
            data_o  <= blank_d ? 8'h00 : bus.display_data;
            blank_o <= blank_d;
            hs_o    <= hs_d;
            vs_o    <= vs_d;
        end
    end

    assign bus.display_next_pixel    = pix_r;
    assign bus.display_next_line     = line_r;
    assign bus.display_next_frame    = frame_r;
    assign bus.display_current_field = field_r;
    assign bus.vid_data              = data_o;
    assign bus.vid_blank             = blank_o;
    assign bus.vid_hsync             = hs_o;
    assign bus.vid_vsync             = vs_o;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a shrunk raster for full-frame/interlace/mode checks
// and a default-geometry instance for real-line pixel and sync counts.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    // Shrunk progressive: 20x10 total, 12x6 active, hsync [14,17), vsync [7,9).
    localparam timing_t TP_S = '{h_act: 11'd12, h_ss: 11'd14, h_se: 11'd17,
                                 h_half: 11'd10, v_act: 10'd6, v_ss: 10'd7,
                                 v_se: 10'd9};
    // Shrunk interlaced: 24 x 7/8, 16x4 active, hsync [18,21), vsync [5,6), half 12.
    localparam timing_t TI_S = '{h_act: 11'd16, h_ss: 11'd18, h_se: 11'd21,
                                 h_half: 11'd12, v_act: 10'd4, v_ss: 10'd5,
                                 v_se: 10'd6};

    localparam int PIX = 0;
    localparam int LIN = 1;
    localparam int FRM = 2;
    localparam int FLD = 3;
    localparam int HSL = 4;
    localparam int VSL = 5;
    localparam int ACT = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    video_timing_if if_s();
    video_timing_if if_b();

    video_timing_gen #(
        .PIPE_DELAY (2),
        .H_TOTAL_P  (20),
        .V_TOTAL_P  (10),
        .H_TOTAL_I  (24),
        .V_TOTAL_I  (7),
        .TP         (TP_S),
        .TI         (TI_S)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    video_timing_gen dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int p = 0;
    int bad_s = 0;
    int bad_b = 0;

    bit [6:0]   obs_s [2000];
    bit [6:0]   obs_b [2000];
    logic [7:0] vd_s  [2000];
    logic [7:0] vd_b  [2000];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt(input bit big, input int b,
                               input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) c += big ? obs_b[i][b] : obs_s[i][b];
        return c;
    endfunction

    function automatic int first(input bit big, input int b,
                                 input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            if (big ? obs_b[i][b] : obs_s[i][b]) return i;
        return -1;
    endfunction

    // Pixel q is the q-th strobe period after reset release.
    function automatic bit act_s(input int q);
        int hq = q % 20;
        int vq = (q / 20) % 10;
        return q >= 0 && hq < 12 && vq < 6;
    endfunction

    function automatic bit act_b(input int q);
        int hq = q % 800;
        int vq = (q / 800) % 525;
        return q >= 0 && hq < 640 && vq < 480;
    endfunction

    // Composer: h[7:0] for active pixels, 0xFF junk while blanked.
    function automatic logic [7:0] drv_s(input int q);
        int hq = q % 20;
        if (q < 0) return 8'h00;
        return act_s(q) ? hq[7:0] : 8'hFF;
    endfunction

    function automatic logic [7:0] drv_b(input int q);
        int hq = q % 800;
        if (q < 0) return 8'h00;
        return act_b(q) ? hq[7:0] : 8'hFF;
    endfunction

    // Output in period k carries pixel k-3 (strobe, 2 periods of data, capture).
    function automatic logic [7:0] exp_s(input int k);
        int q = k - 3;
        int hq = q % 20;
        return act_s(q) ? hq[7:0] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_b(input int k);
        int q = k - 3;
        int hq = q % 800;
        return act_b(q) ? hq[7:0] : 8'h00;
    endfunction

    // One pixel period per iteration: sample after the enabled edge,
    // then present the data the composer owes for pixel p-2.
    task automatic run(input int n, input bit data_on);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs_s[p] = {~if_s.vid_blank, ~if_s.vid_vsync, ~if_s.vid_hsync,
                        if_s.display_current_field, if_s.display_next_frame,
                        if_s.display_next_line, if_s.display_next_pixel};
            obs_b[p] = {~if_b.vid_blank, ~if_b.vid_vsync, ~if_b.vid_hsync,
                        if_b.display_current_field, if_b.display_next_frame,
                        if_b.display_next_line, if_b.display_next_pixel};
            vd_s[p] = if_s.vid_data;
            vd_b[p] = if_b.vid_data;
            if (data_on) begin
                if (p < 400 && if_s.vid_data !== exp_s(p)) bad_s++;
                if (if_b.vid_data !== exp_b(p)) bad_b++;
                if_s.display_data = drv_s(p - 2);
                if_b.display_data = drv_b(p - 2);
            end
            p++;
            @(posedge clk);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pix_first_en", if_s.display_next_pixel, 0);
    endtask

    initial begin
        if_s.interlaced   = 1'b0;
        if_s.display_data = 8'h00;
        if_b.interlaced   = 1'b0;
        if_b.display_data = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_s", {if_s.display_next_pixel, if_s.display_next_line,
                        if_s.display_next_frame, if_s.display_current_field,
                        if_s.vid_data, if_s.vid_hsync, if_s.vid_vsync,
                        if_s.vid_blank}, 32'h0007);
        chk("reset_b", {if_b.display_next_pixel, if_b.display_next_line,
                        if_b.display_next_frame, if_b.display_current_field,
                        if_b.vid_data, if_b.vid_hsync, if_b.vid_vsync,
                        if_b.vid_blank}, 32'h0007);

        release_reset();
        run(1, 1'b1);
        chk("pix_first", obs_s[0][PIX], 1);
        #1;
        chk("pix_held", if_s.display_next_pixel, 1);
        run(250, 1'b1);
        if_s.interlaced = 1'b1;
        run(1650, 1'b1);

        chk("p_pix_cnt", cnt(0, PIX, 0, 200), 72);
        chk("p_line_cnt", cnt(0, LIN, 0, 200), 10);
        chk("p_line_first", first(0, LIN, 0, 200), 19);
        chk("p_frame_cnt", cnt(0, FRM, 0, 200), 1);
        chk("p_frame_at", first(0, FRM, 0, 200), 199);
        chk("p_field_zero", cnt(0, FLD, 0, 400), 0);
        chk("p_active_cnt", cnt(0, ACT, 0, 200), 72);
        chk("p_active_first", first(0, ACT, 0, 200), 3);
        chk("p_hs_cnt", cnt(0, HSL, 0, 200), 30);
        chk("p_hs_first", first(0, HSL, 0, 200), 17);
        chk("p_vs_cnt", cnt(0, VSL, 0, 200), 40);
        chk("p_vs_first", first(0, VSL, 0, 200), 143);
        chk("p_data_bad", bad_s, 0);
        chk("p_data_h5", vd_s[8], 5);
        chk("p_data_blank", vd_s[15], 0);

        chk("sw_frame_cnt", cnt(0, FRM, 200, 400), 1);
        chk("sw_frame_at", first(0, FRM, 200, 400), 399);
        chk("sw_line_cnt", cnt(0, LIN, 200, 400), 10);
        chk("sw_pix_cnt", cnt(0, PIX, 200, 400), 72);

        chk("i_line_first", first(0, LIN, 400, 568), 423);
        chk("i_f0_lines", cnt(0, LIN, 400, 568), 7);
        chk("i_f1_lines", cnt(0, LIN, 568, 760), 8);
        chk("i_f0_pix", cnt(0, PIX, 400, 568), 64);
        chk("i_f1_pix", cnt(0, PIX, 568, 760), 64);
        chk("i_f0_end", first(0, FRM, 400, 760), 567);
        chk("i_f0_field", obs_s[567][FLD], 0);
        chk("i_field_upd", obs_s[568][FLD], 1);
        chk("i_f1_end", first(0, FRM, 568, 900), 759);
        chk("i_f1_field", obs_s[759][FLD], 1);
        chk("i_f2_end", first(0, FRM, 760, 1000), 927);
        chk("i_f2_field", obs_s[927][FLD], 0);
        chk("i_hs_cnt", cnt(0, HSL, 400, 568), 21);
        chk("i_f0_vs_first", first(0, VSL, 400, 568), 523);
        chk("i_f1_vs_first", first(0, VSL, 568, 760), 703);
        chk("i_f1_vs_cnt", cnt(0, VSL, 568, 760), 24);

        chk("b_pix_cnt", cnt(1, PIX, 0, 1600), 1280);
        chk("b_line_cnt", cnt(1, LIN, 0, 1600), 2);
        chk("b_line_first", first(1, LIN, 0, 1600), 799);
        chk("b_line_second", first(1, LIN, 800, 1600), 1599);
        chk("b_hs_cnt", cnt(1, HSL, 0, 1600), 192);
        chk("b_hs_first", first(1, HSL, 0, 1600), 659);
        chk("b_active_cnt", cnt(1, ACT, 0, 1600), 1280);
        chk("b_vs_cnt", cnt(1, VSL, 0, 1600), 0);
        chk("b_data_bad", bad_b, 0);
        chk("b_pix_h300", obs_b[1900][PIX], 1);
        chk("b_data_h297", vd_b[1900], 41);

        #5;
        rst_n = 1'b0;
        #1;
        chk("async_s", {if_s.display_next_pixel, if_s.display_next_line,
                        if_s.display_next_frame, if_s.display_current_field,
                        if_s.vid_data, if_s.vid_hsync, if_s.vid_vsync,
                        if_s.vid_blank}, 32'h0007);
        chk("async_b", {if_b.display_next_pixel, if_b.display_next_line,
                        if_b.display_next_frame, if_b.display_current_field,
                        if_b.vid_data, if_b.vid_hsync, if_b.vid_vsync,
                        if_b.vid_blank}, 32'h0007);

        repeat (2) @(posedge clk);
        release_reset();
        p = 0;
        run(20, 1'b0);
        chk("rst_line_first", first(0, LIN, 0, 20), 19);
        chk("rst_pix_cnt", cnt(0, PIX, 0, 20), 12);
        chk("rst_b_pix_cnt", cnt(1, PIX, 0, 20), 20);
        chk("rst_b_line_cnt", cnt(1, LIN, 0, 20), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
